// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ack bus between fetch stage and memory.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: FETCH/HOLD/HALT sequencer with valid/ready output.
// Define FETCH_ALIGN_CHECK_EN to halt on misaligned redirect targets.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     imem,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic [6:0]        op,
    output logic [2:0]        f3,
    output logic              f7,
    output logic              valid,
    input  logic              ready,
    input  logic              pcSrc,
    input  logic [31:0]       pcTarget,
    output logic [31:0]       instr_count,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        req_q, req_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] cnt_q, cnt_n;
    logic        mis_q, mis_n;
    logic [31:0] next_pc;
    logic        bad_tgt;

    assign next_pc = pcSrc ? (pcTarget & ~32'h3) : pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad_tgt    = pcSrc && (pcTarget[1:0] != 2'b00);
    assign misaligned = mis_q;
`else
    assign bad_tgt    = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            cnt_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            instr_q <= instr_n;
            pc_q    <= pc_n;
            cnt_q   <= cnt_n;
            mis_q   <= mis_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = req_q;
        addr_n  = addr_q;
        instr_n = instr_q;
        pc_n    = pc_q;
        cnt_n   = cnt_q;
        mis_n   = mis_q;
        unique case (state)
            FETCH: begin
                // First cycle after reset only raises the request
                if (!req_q) begin
                    req_n = 1'b1;
                end else if (imem.imem_ack) begin
                    instr_n = imem.imem_rdata;
                    pc_n    = addr_q;
                    req_n   = 1'b0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    cnt_n = cnt_q + 32'd1;
                    if (bad_tgt) begin
                        mis_n   = 1'b1;
                        req_n   = 1'b0;
                        state_n = HALT;
                    end else begin
                        addr_n  = next_pc;
                        req_n   = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            HALT: begin
                req_n = 1'b0;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign imem.imem_req  = req_q && (state == FETCH);
    assign imem.imem_addr = addr_q;
    assign valid          = (state == HOLD);
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign op             = instr_q[6:0];
    assign f3             = instr_q[14:12];
    assign f7             = instr_q[30];
    assign instr_count    = cnt_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 The module SHALL have port imem_addr, output, 32 bits: fetch address, valid while imem_req is high.
REQ-006 The module SHALL have port imem_ack, input, 1 bit: memory completion, one cycle wide.
REQ-007 The module SHALL have port imem_rdata, input, 32 bits: instruction word, valid when imem_ack is high.
REQ-008 The module SHALL have port instr, output, 32 bits: latched instruction word.
REQ-009 The module SHALL have port pc, output, 32 bits: address of the instruction on instr.
REQ-010 The module SHALL have ports op (7 bits, instr[6:0]), f3 (3 bits, instr[14:12]) and f7 (1 bit, instr[30]), all outputs, feeding the control unit.
REQ-011 The module SHALL have port valid, output, 1 bit: instr, pc, op, f3 and f7 hold a fetched instruction.
REQ-012 The module SHALL have port ready, input, 1 bit: the datapath consumes the instruction this cycle.
REQ-013 The module SHALL have port pcSrc, input, 1 bit, and port pcTarget, input, 32 bits: control-unit redirect of the next fetch.
REQ-014 The module SHALL have port instr_count, output, 32 bits: count of consumed instructions.
REQ-015 The module SHALL have port misaligned, output, 1 bit: alignment fault flag (see Configuration).

Function
REQ-016 The module SHALL implement states FETCH (imem_req=1), HOLD (valid=1) and HALT (all idle).
REQ-017 In FETCH, imem_req and imem_addr SHALL be held stable until imem_ack is sampled high.
REQ-018 On imem_ack in FETCH, the module SHALL load instr from imem_rdata and pc from imem_addr, and enter HOLD; valid SHALL rise the cycle after the ack.
REQ-019 imem_ack sampled outside FETCH SHALL be ignored, with no state or output change.
REQ-020 In HOLD, outputs SHALL remain stable until valid and ready are both high (handshake).
REQ-021 On handshake with pcSrc=0, the next fetch address SHALL be pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-022 On handshake with pcSrc=1, the next fetch address SHALL be pcTarget.
REQ-023 pcSrc and pcTarget SHALL be sampled only on the handshake cycle and ignored otherwise.
REQ-024 After a handshake, imem_req SHALL assert in the very next cycle and valid SHALL drop in that same cycle.
REQ-025 instr_count SHALL increment by 1 on each handshake, wrap from 32'hFFFF_FFFF to 0, and never change on any other cycle.

Reset
REQ-026 While rst_n=0, state SHALL be FETCH, imem_addr=RESET_PC, imem_req=0, valid=0, instr=0, pc=0, instr_count=0 and misaligned=0.
REQ-027 In the first clock edge after rst_n rises, imem_req SHALL assert with imem_addr=RESET_PC.
REQ-028 Reset asserted mid-fetch or mid-hold SHALL abandon the operation immediately; instruction memory shares rst_n and drops any outstanding access.

Configuration
REQ-029 The macro FETCH_ALIGN_CHECK_EN SHALL select alignment checking at compile time.
REQ-030 With FETCH_ALIGN_CHECK_EN defined, a redirect with pcTarget[1:0]!=0 SHALL enter HALT, set misaligned=1 and hold imem_req=0 and valid=0 until reset.
REQ-031 Without FETCH_ALIGN_CHECK_EN, pcTarget[1:0] SHALL be forced to 2'b00, misaligned SHALL be tied to 0 and HALT SHALL be unreachable.

Verification
REQ-032 The bench SHALL apply reset, release it, ack after 3 cycles with rdata 32'h00500093 -> required: imem_addr=0; valid=1 one cycle after ack; op=7'b0010011, f3=000, f7=0.
REQ-033 The bench SHALL hold ready=0 for 5 cycles then pulse it with pcSrc=0 -> required: outputs stable throughout; next imem_addr=4; instr_count=1.
REQ-034 The bench SHALL complete a handshake with pcSrc=1, pcTarget=32'h40 -> required: next imem_addr=32'h40; pc=32'h40 after the ack.
REQ-035 The bench SHALL pulse a stray imem_ack during HOLD -> required: instr unchanged, no extra valid.
REQ-036 The bench SHALL redirect with pcTarget=32'h42 -> required with the macro: misaligned=1, imem_req=0 until reset; required without it: imem_addr=32'h40.
REQ-037 The bench SHALL assert rst_n=0 mid-fetch at pc=32'h40 -> required: immediate valid=0, instr_count=0, then fetch from RESET_PC.
